// File: rtl/result_reader.sv
// Result readout engine: fetches bytes from the four result banks and streams packed 32-bit words to the host.
// Optional hardware argmax over the streamed bytes is enabled by defining RESULT_READER_ARGMAX_EN.
module result_reader #(
  parameter int ADDR_W     = 11,
  parameter int RES_DEPTH  = 1984,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       control_reg,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_re,
  input  logic [7:0]        res_rdata0,
  input  logic [7:0]        res_rdata1,
  input  logic [7:0]        res_rdata2,
  input  logic [7:0]        res_rdata3,
  output logic [31:0]       readdata,
  output logic              readvalid,
  input  logic              readack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        max_val,
  output logic [12:0]       max_idx
);

  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  DEPTH     = (ADDR_W+1)'(RES_DEPTH);
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;
  state_t state, state_next;

  logic                cmd_read, cmd_prev, start, abort, push, pop, in_range, clamped;
  logic [ADDR_W:0]     avail, len, remaining;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                inflight;
  logic [31:0]         push_word;
  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  fifo_wp, fifo_rp;
  logic [FIFO_AW:0]    fifo_cnt;

  always_comb begin
    cmd_read  = (control_reg == 32'h3);
    start     = cmd_read && !cmd_prev && (state == IDLE);
    abort     = (control_reg == '0) && ((state == FETCH) || (state == DRAIN));
    readvalid = (fifo_cnt != '0);
    readdata  = fifo_mem[fifo_rp];
    pop       = readack && readvalid && !abort;
    push      = inflight && !abort;
    push_word = {res_rdata0, res_rdata1, res_rdata2, res_rdata3};
    res_addr  = rd_ptr;
    in_range  = ({1'b0, start_addr} < DEPTH);
    avail     = in_range ? (DEPTH - {1'b0, start_addr}) : '0;
    len       = (word_count > avail) ? avail : word_count;
    clamped   = (word_count > avail) || !in_range;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start) state_next = (len == '0) ? FINISH : FETCH;
      FETCH:  if (abort) state_next = IDLE;
              else if (res_re && (remaining == (ADDR_W+1)'(1))) state_next = DRAIN;
      // Leave DRAIN on the final pop itself so done lands in the cycle right after it.
      DRAIN:  if (abort) state_next = IDLE;
              else if (!inflight && ((fifo_cnt == '0) ||
                       ((fifo_cnt == (FIFO_AW+1)'(1)) && pop))) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == FETCH) || (state == DRAIN);
    done   = (state == FINISH);
    res_re = (state == FETCH) && !abort && (remaining != '0) &&
             ((fifo_cnt + (FIFO_AW+1)'(inflight)) < FIFO_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_prev  <= 1'b0;
      rd_ptr    <= '0;
      remaining <= '0;
      err       <= 1'b0;
      inflight  <= 1'b0;
      fifo_wp   <= '0;
      fifo_rp   <= '0;
      fifo_cnt  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      cmd_prev <= cmd_read;
      inflight <= res_re;
      if (start) begin
        // Out-of-range starts park the pointer at 0 so it never leaves the valid window.
        rd_ptr    <= in_range ? start_addr : '0;
        remaining <= len;
        err       <= clamped;
      end else if (res_re) begin
        remaining <= remaining - (ADDR_W+1)'(1);
        if (remaining != (ADDR_W+1)'(1)) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (abort) begin
        fifo_wp  <= '0;
        fifo_rp  <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) begin
          fifo_mem[fifo_wp] <= push_word;
          fifo_wp           <= fifo_wp + FIFO_AW'(1);
        end
        if (pop) fifo_rp <= fifo_rp + FIFO_AW'(1);
        if (push && !pop)      fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
        else if (!push && pop) fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
      end
    end
  end

`ifdef RESULT_READER_ARGMAX_EN
  logic [ADDR_W-1:0] push_idx;
  logic [12:0]       base_idx, best_idx;
  logic [7:0]        best_val;

  // Bytes are scanned bank0..bank3 with a strict compare so ties keep the earlier index.
  always_comb begin
    base_idx = 13'(push_idx) << 2;
    best_val = max_val;
    best_idx = max_idx;
    for (int unsigned b = 0; b < 4; b++) begin
      if ($signed(push_word[8*(3-b) +: 8]) > $signed(best_val)) begin
        best_val = push_word[8*(3-b) +: 8];
        best_idx = base_idx + 13'(b);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val  <= 8'h80;
      max_idx  <= '0;
      push_idx <= '0;
    end else if (start) begin
      max_val  <= 8'h80;
      max_idx  <= '0;
      push_idx <= '0;
    end else if (push) begin
      max_val  <= best_val;
      max_idx  <= best_idx;
      push_idx <= push_idx + ADDR_W'(1);
    end
  end
`else
  assign max_val = 8'h80;
  assign max_idx = '0;
`endif

endmodule

// File: tb/tb_result_reader.sv
// Randomized self-checking bench for result_reader: queue-based reference of the expected word stream,
// occupancy, error flag and argmax, with a behavioural model of the four result banks.
module tb_result_reader;
  localparam int ADDR_W     = 11;
  localparam int RES_DEPTH  = 1984;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       control_reg = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic [ADDR_W-1:0] res_addr;
  logic              res_re;
  logic [7:0]        res_rdata0 = '0, res_rdata1 = '0, res_rdata2 = '0, res_rdata3 = '0;
  logic [31:0]       readdata;
  logic              readvalid;
  logic              readack = 1'b0;
  logic              busy, done, err;
  logic [7:0]        max_val;
  logic [12:0]       max_idx;

  logic [7:0]  ram [4][2048];
  int          total = 0;
  int          bad = 0;
  logic [31:0] first_word;

  result_reader #(.ADDR_W(ADDR_W), .RES_DEPTH(RES_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .control_reg(control_reg), .start_addr(start_addr),
    .word_count(word_count), .res_addr(res_addr), .res_re(res_re),
    .res_rdata0(res_rdata0), .res_rdata1(res_rdata1), .res_rdata2(res_rdata2),
    .res_rdata3(res_rdata3), .readdata(readdata), .readvalid(readvalid), .readack(readack),
    .busy(busy), .done(done), .err(err), .max_val(max_val), .max_idx(max_idx)
  );

  always #5 clk = ~clk;

  // Result banks: one-cycle read latency.
  always @(posedge clk) begin
    if (res_re) begin
      res_rdata0 <= ram[0][res_addr];
      res_rdata1 <= ram[1][res_addr];
      res_rdata2 <= ram[2][res_addr];
      res_rdata3 <= ram[3][res_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  32'(res_addr), 0);
    check({tag, "_re"},    32'(res_re), 0);
    check({tag, "_data"},  readdata, 0);
    check({tag, "_valid"}, 32'(readvalid), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_mval"},  32'(max_val), 32'h80);
    check({tag, "_midx"},  32'(max_idx), 0);
  endtask

  // Negedge j of the loop lies in the cycle after start edge N + j - 1.
  task automatic run_xfer(input int addr, input int cnt, input int ack_pct,
                          input int restart_j, input int abort_j);
    logic [31:0] expq[$];
    logic [31:0] wv;
    logic [7:0]  bv;
    logic signed [7:0] mv;
    int avail, len, j, first_valid, done_n, re_n, pops, occ, occ_max, budget, tail;
    int post_re, post_valid, mi;
    bit exp_err, re_d1, re_d2, pop_prev, aborted;

    avail   = (addr < RES_DEPTH) ? RES_DEPTH - addr : 0;
    len     = (cnt < avail) ? cnt : avail;
    exp_err = (cnt > avail) || (addr >= RES_DEPTH);
    for (int a = addr; a < addr + len; a++)
      expq.push_back({ram[0][a], ram[1][a], ram[2][a], ram[3][a]});
    mv = -8'sd128;
    mi = 0;
    for (int w = 0; w < len; w++) begin
      wv = expq[w];
      for (int k = 0; k < 4; k++) begin
        bv = wv[8*(3-k) +: 8];
        if ($signed(bv) > mv) begin
          mv = $signed(bv);
          mi = w * 4 + k;
        end
      end
    end

    @(negedge clk);
    start_addr  = ADDR_W'(addr);
    word_count  = (ADDR_W+1)'(cnt);
    control_reg = 32'h3;
    j = 0; first_valid = -1; done_n = 0; re_n = 0; pops = 0; occ = 0; occ_max = 0;
    tail = 0; post_re = 0; post_valid = 0;
    re_d1 = 0; re_d2 = 0; pop_prev = 0; aborted = 0;
    budget = 4 * len + 60;
    while (j < budget) begin
      @(negedge clk);
      j++;
      if (done) done_n++;
      if (aborted) begin
        if (res_re) post_re++;
        if (readvalid) post_valid++;
        tail++;
        if (tail >= 8) break;
        continue;
      end
      if (abort_j > 0 && j == abort_j + 1) begin
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(readvalid), 0);
        aborted = 1;
        control_reg = 32'h1;
        continue;
      end
      occ = occ + int'(re_d2) - int'(pop_prev);
      if (occ > occ_max) occ_max = occ;
      check("valid", 32'(readvalid), 32'(occ != 0));
      if (res_re) re_n++;
      if (readvalid && first_valid < 0) first_valid = j;
      re_d2 = re_d1;
      re_d1 = res_re;
      if (done_n > 0) begin
        tail++;
        if (tail >= 4) break;
      end
      if (abort_j > 0 && j == abort_j) control_reg = '0;
      if (restart_j > 0 && j == restart_j) control_reg = 32'h1;
      if (restart_j > 0 && j == restart_j + 1) begin
        control_reg = 32'h3;
        start_addr  = ADDR_W'($urandom);
        word_count  = (ADDR_W+1)'($urandom_range(1, 4095));
      end
      readack  = ($urandom_range(0, 99) < ack_pct);
      pop_prev = readvalid && readack;
      if (pop_prev) begin
        if (pops < len) check("word", readdata, expq[pops]);
        else            check("extra_word", 32'(pops), 32'(len));
        if (pops == 0) first_word = readdata;
        pops++;
      end
    end
    readack = 1'b0;
    control_reg = 32'h1;

    if (abort_j > 0) begin
      check("abort_reached", 32'(aborted), 1);
      check("abort_done", 32'(done_n), 0);
      check("abort_re", 32'(post_re), 0);
      check("abort_valid_after", 32'(post_valid), 0);
    end else begin
      check("done_count", 32'(done_n), 1);
      check("words", 32'(pops), 32'(len));
      check("reads", 32'(re_n), 32'(len));
      check("err", 32'(err), 32'(exp_err));
      check("first_valid", 32'(first_valid), (len > 0) ? 32'd3 : 32'hFFFF_FFFF);
      check("occ_max_le4", 32'(occ_max <= FIFO_DEPTH), 1);
      check("idle_valid", 32'(readvalid), 0);
`ifdef RESULT_READER_ARGMAX_EN
      check("max_val", 32'(max_val), 32'(8'(mv)));
      check("max_idx", 32'(max_idx), 32'(mi));
`else
      check("max_val", 32'(max_val), 32'h80);
      check("max_idx", 32'(max_idx), 0);
`endif
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++)
      for (int k = 0; k < 4; k++) ram[k][a] = 8'(a + k);

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    control_reg = 32'h1;
    repeat (2) @(negedge clk);

    // Full readout of the patterned banks.
    run_xfer(0, 1984, 100, 0, 0);
    check("first_word", first_word, 32'h0001_0203);

    for (int a = 0; a < 2048; a++)
      for (int k = 0; k < 4; k++) ram[k][a] = 8'($urandom);

    run_xfer(1568, 288, 50, 0, 0);          // backpressure
    run_xfer(1980, 10, 70, 0, 0);           // clamp: 4 words, err set
    check("clamp_err", 32'(err), 1);
    run_xfer(100, 50, 60, 0, 0);            // clears err
    check("clear_err", 32'(err), 0);
    run_xfer(500, 0, 100, 0, 0);            // zero count
    run_xfer(0, 200, 100, 6, 0);            // restart while busy ignored
    run_xfer(300, 100, 0, 0, 4);            // abort mid-FETCH
    run_xfer(10, 20, 80, 0, 0);             // recovery after abort

    // Asynchronous reset mid-transfer.
    @(negedge clk);
    start_addr = 11'd0;
    word_count = 12'd100;
    control_reg = 32'h3;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    control_reg = 32'h1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", 32'(busy), 0);
    check("post_reset_valid", 32'(readvalid), 0);

    // Argmax over conv5: a single 8'h7F at bank2 of address 1900.
    for (int a = 1856; a < 1984; a++)
      for (int k = 0; k < 4; k++) begin
        ram[k][a] = 8'($urandom);
        if (ram[k][a] == 8'h7F) ram[k][a] = 8'h7E;
      end
    ram[2][1900] = 8'h7F;
    run_xfer(1856, 128, 70, 0, 0);
`ifdef RESULT_READER_ARGMAX_EN
    check("argmax_val", 32'(max_val), 32'h7F);
    check("argmax_idx", 32'(max_idx), 178);
`else
    check("argmax_val", 32'(max_val), 32'h80);
    check("argmax_idx", 32'(max_idx), 0);
`endif

    for (int t = 0; t < 4; t++)
      run_xfer($urandom_range(0, 2047), $urandom_range(0, 300), $urandom_range(20, 100), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
